// File: rtl/score_pkg.sv
// Shared score display definitions: round states, dash pattern and digit encoder.
package score_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_FINAL = 2'd2
  } state_t;

  localparam int unsigned SEG_W    = 7;
  localparam int unsigned BCD_W    = 4;
  localparam logic [6:0]  SEG_DASH = 7'b0111111;

  // Active-low seven-segment pattern, bit6=g .. bit0=a; out-of-range values show dash.
  function automatic logic [6:0] digit_seg(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hit_debouncer.sv
// Two-flop synchroniser, run-length debouncer and registered rising-edge pulse.
module hit_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_raw,
  output logic pulse
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= in_raw;
      sync2 <= sync1;
    end
  end

  // Level flips after DEBOUNCE_CYCLES consecutive differing samples; pulse marks 0->1 flips.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= ~level;
        pulse <= ~level;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/score_encoder.sv
// Round sequencer and saturating single-digit hit counter driving the score display.
module score_encoder
  import score_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned MAX_SCORE       = 9
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       time_up,
  input  logic       hit_raw,
  output logic [6:0] score_seg,
  output logic [3:0] score_bcd,
  output logic       score_strobe,
  output logic       game_over
);

  localparam logic [BCD_W-1:0] MAX_BCD = BCD_W'(MAX_SCORE);
  localparam logic [SEG_W-1:0] SEG_ZERO = digit_seg(4'd0);

  logic             hit;
  state_t           state;
  state_t           state_nxt;
  logic [BCD_W-1:0] bcd_nxt;
  logic [SEG_W-1:0] seg_nxt;
  logic             strobe_nxt;
  logic             game_over_nxt;
  logic [BCD_W-1:0] bcd_inc;

  hit_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_hit_debouncer (
    .clk    (clk),
    .reset_n(reset_n),
    .in_raw (hit_raw),
    .pulse  (hit)
  );

  assign bcd_inc = score_bcd + BCD_W'(1);

  // Next state and outputs; priority is start, then time_up, then hit.
  always_comb begin
    state_nxt  = state;
    bcd_nxt    = score_bcd;
    seg_nxt    = score_seg;
    strobe_nxt = 1'b0;
    if (start) begin
      state_nxt  = ST_PLAY;
      bcd_nxt    = '0;
      seg_nxt    = SEG_ZERO;
      strobe_nxt = (score_seg != SEG_ZERO);
    end else begin
      case (state)
        ST_PLAY: begin
          if (time_up) begin
            state_nxt = ST_FINAL;
          end else if (hit && (score_bcd < MAX_BCD)) begin
            bcd_nxt    = bcd_inc;
            seg_nxt    = digit_seg(bcd_inc);
            strobe_nxt = 1'b1;
          end
        end
        ST_FINAL: state_nxt = ST_FINAL;
        default:  state_nxt = ST_IDLE;
      endcase
    end
    game_over_nxt = (state_nxt == ST_FINAL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      score_bcd    <= '0;
      score_seg    <= SEG_DASH;
      score_strobe <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      state        <= state_nxt;
      score_bcd    <= bcd_nxt;
      score_seg    <= seg_nxt;
      score_strobe <= strobe_nxt;
      game_over    <= game_over_nxt;
    end
  end

endmodule

// File: tb/tb_score_encoder.sv
// Bench for score_encoder: behavioural round/debounce model checked every cycle plus directed literals.
module tb_score_encoder;

  localparam int D   = 16;
  localparam int MAX = 9;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       time_up = 1'b0;
  logic       hit_raw = 1'b0;
  logic [6:0] score_seg;
  logic [3:0] score_bcd;
  logic       score_strobe;
  logic       game_over;

  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  logic [6:0] digits [10];
  initial begin
    digits[0] = 7'b1000000; digits[1] = 7'b1111001; digits[2] = 7'b0100100;
    digits[3] = 7'b0110000; digits[4] = 7'b0011001; digits[5] = 7'b0010010;
    digits[6] = 7'b0000010; digits[7] = 7'b1111000; digits[8] = 7'b0000000;
    digits[9] = 7'b0010000;
  end
  localparam logic [6:0] DASH = 7'b0111111;

  score_encoder #(.DEBOUNCE_CYCLES(D), .MAX_SCORE(MAX)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .time_up(time_up), .hit_raw(hit_raw),
    .score_seg(score_seg), .score_bcd(score_bcd), .score_strobe(score_strobe),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      if (fails < 40) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: samples reach the debouncer two edges late; a run of D samples
  // different from the accepted level flips it; a rise counts one edge later.
  int  m_s1, m_s2, m_lvl, m_run, m_pend;
  int  m_phase;   // 0 idle, 1 play, 2 final
  int  m_score;
  logic [6:0] m_seg;
  int  m_strobe;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0; m_pend = 0;
      m_phase = 0; m_score = 0; m_seg = DASH; m_strobe = 0;
    end else begin
      int hit_now;
      int new_pend;
      logic [6:0] prev_seg;
      hit_now = m_pend;
      new_pend = 0;
      if (m_s2 == m_lvl) m_run = 0;
      else begin
        m_run++;
        if (m_run == D) begin
          m_lvl = 1 - m_lvl;
          m_run = 0;
          new_pend = m_lvl;
        end
      end
      m_s2 = m_s1;
      m_s1 = int'(hit_raw);
      m_pend = new_pend;

      prev_seg = m_seg;
      m_strobe = 0;
      if (start) begin
        m_phase = 1; m_score = 0; m_seg = digits[0];
        m_strobe = (prev_seg != digits[0]) ? 1 : 0;
      end else if (m_phase == 1) begin
        if (time_up) m_phase = 2;
        else if (hit_now == 1 && m_score < MAX) begin
          m_score++;
          m_seg = digits[m_score];
          m_strobe = 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (checking) begin
      check("score_bcd", int'(score_bcd), m_score);
      check("score_seg", int'(score_seg), int'(m_seg));
      check("score_strobe", int'(score_strobe), m_strobe);
      check("game_over", int'(game_over), (m_phase == 2) ? 1 : 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic pulse_time_up();
    time_up = 1'b1; tick(1); time_up = 1'b0;
  endtask

  task automatic clean_hit();
    hit_raw = 1'b1; tick(40); hit_raw = 1'b0; tick(40);
  endtask

  initial begin
    int k;
    logic [3:0] prev;
    tick(3);
    check("reset_seg", int'(score_seg), int'(DASH));
    check("reset_bcd", int'(score_bcd), 0);
    check("reset_game_over", int'(game_over), 0);
    reset_n = 1'b1;
    checking = 1'b1;
    tick(2);

    // Three clean hits, with increment latency measured on each
    pulse_start();
    check("start_seg", int'(score_seg), int'(digits[0]));
    for (int h = 0; h < 3; h++) begin
      prev = score_bcd;
      hit_raw = 1'b1;
      k = 0;
      for (int e = 1; e <= 60; e++) begin
        tick(1);
        if (score_bcd != prev) begin k = e; break; end
      end
      check("hit_latency", k, D + 3);
      tick(40 - k);
      hit_raw = 1'b0;
      tick(40);
    end
    check("three_hits_bcd", int'(score_bcd), 3);
    check("three_hits_seg", int'(score_seg), 7'b0110000);

    // Glitches 1..15 then a bouncy 30-cycle pulse
    for (int g = 1; g < D; g++) begin
      hit_raw = 1'b1; tick(g); hit_raw = 1'b0; tick(20);
    end
    check("glitch_bcd", int'(score_bcd), 3);
    hit_raw = 1; tick(1); hit_raw = 0; tick(2); hit_raw = 1; tick(3); hit_raw = 0; tick(1);
    hit_raw = 1; tick(30);
    hit_raw = 0; tick(2); hit_raw = 1; tick(1); hit_raw = 0; tick(3); hit_raw = 1; tick(2);
    hit_raw = 0; tick(40);
    check("bounce_bcd", int'(score_bcd), 4);

    // Saturation after twelve hits
    pulse_start();
    repeat (12) clean_hit();
    check("sat_bcd", int'(score_bcd), 9);
    check("sat_seg", int'(score_seg), 7'b0010000);

    // time_up at 5, hits ignored, restart
    pulse_start();
    repeat (5) clean_hit();
    pulse_time_up();
    repeat (2) clean_hit();
    check("final_game_over", int'(game_over), 1);
    check("final_seg", int'(score_seg), 7'b0010010);
    pulse_start();
    check("restart_seg", int'(score_seg), 7'b1000000);
    check("restart_game_over", int'(game_over), 0);

    // start with time_up at 4
    repeat (4) clean_hit();
    start = 1'b1; time_up = 1'b1; tick(1); start = 1'b0; time_up = 1'b0;
    check("start_wins_bcd", int'(score_bcd), 0);
    check("start_wins_go", int'(game_over), 0);
    // hit aligned with time_up: pulse is high in the cycle after edge D+2
    clean_hit();
    hit_raw = 1'b1; tick(D + 2);
    time_up = 1'b1; tick(1); time_up = 1'b0;
    tick(20); hit_raw = 1'b0; tick(40);
    check("aligned_hit_bcd", int'(score_bcd), 1);
    check("aligned_hit_go", int'(game_over), 1);

    // Reset mid-round at 6, mid-debounce
    pulse_start();
    repeat (6) clean_hit();
    check("pre_reset_bcd", int'(score_bcd), 6);
    hit_raw = 1'b1; tick(8);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_seg", int'(score_seg), int'(DASH));
    check("async_reset_bcd", int'(score_bcd), 0);
    check("async_reset_strobe", int'(score_strobe), 0);
    tick(2);
    reset_n = 1'b1;
    tick(40); hit_raw = 1'b0; tick(10);
    repeat (2) clean_hit();
    check("idle_ignores_seg", int'(score_seg), int'(DASH));
    check("idle_ignores_bcd", int'(score_bcd), 0);

    // Randomised phase
    begin
      int run_left;
      run_left = 0;
      for (int c = 0; c < 6000; c++) begin
        if (run_left == 0) begin
          hit_raw = ~hit_raw;
          run_left = (($urandom_range(0, 3) == 0) ? $urandom_range(1, D - 1) : $urandom_range(D, 45));
        end
        run_left--;
        start   = ($urandom_range(0, 399) == 0);
        time_up = ($urandom_range(0, 299) == 0);
        tick(1);
      end
      start = 1'b0; time_up = 1'b0; hit_raw = 1'b0;
      tick(5);
    end

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
